// File: rtl/seq_mult_hs_if.sv
// Operand/product handshake bundle for seq_mult_hs.
// The slave modport is the multiplier; master is the producer/consumer side.
interface seq_mult_hs_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_p;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/seq_mult_hs.sv
// Iterative shift-add multiplier, one partial product per clock, valid/ready on both sides.
// Define MULT_SIGNED_EN for two's-complement operands and product (default: unsigned).
module seq_mult_hs #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  seq_mult_hs_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_n;
  logic [WIDTH-1:0]     mcand, mult;
  logic [2*WIDTH-1:0]   acc, acc_next, result, out_p;
  logic [CW-1:0]        cnt;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 last, ready, valid;
`ifdef MULT_SIGNED_EN
  logic                 neg;
`endif

  assign last = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    ready   = 1'b0;
    valid   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) state_n = BUSY;
      end
      BUSY: if (last) state_n = DONE;
      DONE: begin
        valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Add into the upper half keeping the carry, then shift the whole accumulator right.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mult[0] ? mcand : '0)};
    acc_next = {sum, acc[WIDTH-1:1]};
`ifdef MULT_SIGNED_EN
    mag_a  = bus.in_a[WIDTH-1] ? -bus.in_a : bus.in_a;
    mag_b  = bus.in_b[WIDTH-1] ? -bus.in_b : bus.in_b;
    result = neg ? -acc_next : acc_next;
`else
    mag_a  = bus.in_a;
    mag_b  = bus.in_b;
    result = acc_next;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      mult  <= '0;
      acc   <= '0;
      cnt   <= '0;
      out_p <= '0;
`ifdef MULT_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          mcand <= mag_a;
          mult  <= mag_b;
          acc   <= '0;
          cnt   <= '0;
`ifdef MULT_SIGNED_EN
          neg   <= bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
`endif
        end
        BUSY: begin
          acc  <= acc_next;
          mult <= mult >> 1;
          cnt  <= cnt + 1'b1;
          if (last) out_p <= result;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.out_p     = out_p;

endmodule

// File: tb/tb_seq_mult_hs.sv
// Directed self-checking bench for seq_mult_hs (WIDTH=8); expectations follow MULT_SIGNED_EN.
module tb_seq_mult_hs;
  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_mult_hs_if #(.WIDTH(W)) bus ();

  seq_mult_hs #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until out_valid, bounded; reports cycles taken and whether in_ready stayed low.
  task automatic wait_prod(output int lat, output logic busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    do begin
      step();
      lat++;
      if (bus.in_ready !== 1'b0 && bus.out_valid !== 1'b1) busy_ok = 1'b0;
      if (bus.out_valid === 1'b1 && bus.in_ready !== 1'b0) busy_ok = 1'b0;
    end while (bus.out_valid !== 1'b1 && lat < 40);
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp);
    int   lat;
    logic busy_ok;
    chk({tag, "_ready_before"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    step();
    bus.in_valid = 1'b0;
    bus.in_a     = 8'($urandom);
    bus.in_b     = 8'($urandom);
    wait_prod(lat, busy_ok);
    chk({tag, "_latency"}, lat, W);
    chk({tag, "_busy_ready"}, busy_ok, 1);
    chk({tag, "_product"}, bus.out_p, exp);
    step();
    chk({tag, "_valid_drop"}, bus.out_valid, 0);
    chk({tag, "_ready_back"}, bus.in_ready, 1);
    chk({tag, "_hold"}, bus.out_p, exp);
  endtask

  initial begin
    int   lat;
    logic busy_ok;
    int   cyc, nacc, nout;
    int   acc_t [2];
    logic [15:0] exp_ff, exp_fd;

    checks = 0;
    errors = 0;
`ifdef MULT_SIGNED_EN
    exp_ff = 16'd1;
    exp_fd = 16'hFFF1;
`else
    exp_ff = 16'd65025;
    exp_fd = 16'd1265;
`endif

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_p", bus.out_p, 0);
    rst_n = 1'b1;
    step();

    run("m3x5", 8'd3, 8'd5, 16'd15);
    run("m255x255", 8'd255, 8'd255, exp_ff);
    run("m0x200", 8'd0, 8'd200, 16'd0);
    run("mFDx5", 8'hFD, 8'd5, exp_fd);
    run("m80x80", 8'h80, 8'h80, 16'h4000);

    // Backpressure: product 132 held five cycles while a new pair waits.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'd12;
    bus.in_b      = 8'd11;
    step();
    bus.in_a = 8'd6;
    bus.in_b = 8'd7;
    wait_prod(lat, busy_ok);
    chk("bp_latency", lat, W);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid_held", bus.out_valid, 1);
      chk("bp_p_stable", bus.out_p, 132);
      chk("bp_no_accept", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_release_valid", bus.out_valid, 0);
    chk("bp_release_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_next_accepted", bus.in_ready, 0);
    wait_prod(lat, busy_ok);
    chk("bp_next_latency", lat, W);
    chk("bp_next_product", bus.out_p, 42);
    step();

    // Reset four edges into BUSY discards the operation.
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd13;
    bus.in_b     = 8'd17;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    chk("mid_rst_p", bus.out_p, 0);
    step();
    rst_n = 1'b1;
    step();
    run("m7x9", 8'd7, 8'd9, 16'd63);

    // Back-to-back with in_valid held: 2*3 then 10*10.
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd2;
    bus.in_b     = 8'd3;
    cyc  = 0;
    nacc = 0;
    nout = 0;
    acc_t[0] = 0;
    acc_t[1] = 0;
    for (int i = 0; i < 60 && nout < 2; i++) begin
      if (bus.in_valid && bus.in_ready && nacc < 2) begin
        acc_t[nacc] = cyc;
        nacc++;
      end
      step();
      cyc++;
      if (nacc == 1) begin
        bus.in_a = 8'd10;
        bus.in_b = 8'd10;
      end
      if (nacc == 2) bus.in_valid = 1'b0;
      if (bus.out_valid === 1'b1) begin
        chk("b2b_product", bus.out_p, (nout == 0) ? 32'd6 : 32'd100);
        nout++;
      end
    end
    chk("b2b_count", nout, 2);
    chk("b2b_spacing", acc_t[1] - acc_t[0], W + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
